// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared combinational ALU.
//
// A requester handshake in IDLE latches its operands into the ALU operand
// registers; the ALU result is captured one cycle later (EXEC) and held on
// the shared response bus until the granted requester accepts it (RESP).
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/ready/a/b/ctrl     request channels, N = 0, 1
//   rspN_valid/ready              response handshakes, N = 0, 1
//   rsp_out, rsp_is_zero          shared response payload
//   alu_a, alu_b, alu_ctrl        registered operands to the ALU
//   alu_out, alu_is_zero          ALU result
//   busy                          high whenever the FSM is not in IDLE
//
// Build option
//   ALU_ARBITER_RR_EN  defined: round-robin between simultaneous requests.
//                      undefined: requester 0 always wins a tie and no
//                      priority register exists.
//
// state | meaning
// IDLE  | waiting for a request; ready offered to the arbitration winner
// EXEC  | operands stable at the ALU; result captured at end of cycle
// RESP  | response held for the granted requester until it is accepted

module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp_out,
    output logic              rsp_is_zero,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_is_zero,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic [WIDTH-1:0]    alu_a_q, alu_a_d;
    logic [WIDTH-1:0]    alu_b_q, alu_b_d;
    logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
    logic [WIDTH-1:0]    rsp_out_q, rsp_out_d;
    logic                rsp_is_zero_q, rsp_is_zero_d;
    logic                sel_valid;
    logic                sel_grant;
`ifdef ALU_ARBITER_RR_EN
    // prio_q names the requester that wins a tie (0 after reset)
    logic                prio_q, prio_d;
`endif

    // Arbitration: a lone requester always wins; a tie is broken by priority.
    always_comb begin
        sel_valid = req0_valid | req1_valid;
`ifdef ALU_ARBITER_RR_EN
        if (req0_valid && req1_valid) begin
            sel_grant = prio_q;
        end else begin
            sel_grant = req1_valid;
        end
`else
        sel_grant = ~req0_valid & req1_valid;
`endif
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_ctrl_d    = alu_ctrl_q;
        rsp_out_d     = rsp_out_q;
        rsp_is_zero_d = rsp_is_zero_q;
`ifdef ALU_ARBITER_RR_EN
        prio_d        = prio_q;
`endif
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        rsp0_valid    = 1'b0;
        rsp1_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                // Ready is only offered to a valid winner, so offering it is
                // the handshake; it is suppressed while reset is asserted.
                if (sel_valid && !rst) begin
                    req0_ready = ~sel_grant;
                    req1_ready = sel_grant;
                    grant_d    = sel_grant;
                    alu_a_d    = sel_grant ? req1_a    : req0_a;
                    alu_b_d    = sel_grant ? req1_b    : req0_b;
                    alu_ctrl_d = sel_grant ? req1_ctrl : req0_ctrl;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                rsp_out_d     = alu_out;
                rsp_is_zero_d = alu_is_zero;
                state_d       = RESP;
            end
            RESP: begin
                rsp0_valid = ~grant_q;
                rsp1_valid = grant_q;
                if (grant_q ? rsp1_ready : rsp0_ready) begin
                    state_d = IDLE;
`ifdef ALU_ARBITER_RR_EN
                    prio_d  = ~grant_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_ctrl_q    <= '0;
            rsp_out_q     <= '0;
            rsp_is_zero_q <= 1'b0;
`ifdef ALU_ARBITER_RR_EN
            prio_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_ctrl_q    <= alu_ctrl_d;
            rsp_out_q     <= rsp_out_d;
            rsp_is_zero_q <= rsp_is_zero_d;
`ifdef ALU_ARBITER_RR_EN
            prio_q        <= prio_d;
`endif
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign rsp_out     = rsp_out_q;
    assign rsp_is_zero = rsp_is_zero_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter CTRL_W, default 4, ALU control code width.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports reqN_valid  input  1, reqN_ready  output  1, reqN_a  input  WIDTH, reqN_b  input  WIDTH, reqN_ctrl  input  CTRL_W, for N = 0, 1 (requester 0 and requester 1).
REQ-006 SHALL have ports rspN_valid  output  1  and rspN_ready  input  1, for N = 0, 1.
REQ-007 SHALL have ports rsp_out  output  WIDTH  result, and rsp_is_zero  output  1  zero flag, shared by both response channels.
REQ-008 SHALL have ports alu_a  output  WIDTH, alu_b  output  WIDTH, alu_ctrl  output  CTRL_W, to the combinational ALU.
REQ-009 SHALL have ports alu_out  input  WIDTH  and alu_is_zero  input  1, from the ALU.
REQ-010 SHALL have port busy  output  1, high in any state other than IDLE.

Function
REQ-011 SHALL implement the FSM states IDLE, EXEC and RESP.
- IDLE: reqN_ready is high for the requester selected per REQ-012, and 0 otherwise. On a handshake (valid && ready), a, b and ctrl are latched into the alu_a, alu_b and alu_ctrl registers, the grant is recorded, and the FSM goes to EXEC.
- EXEC: lasts exactly one cycle. alu_out and alu_is_zero are captured into rsp_out and rsp_is_zero. The FSM goes to RESP.
- RESP: rspG_valid is high for the granted G only. The FSM stays in RESP until rspG_ready is high, then returns to IDLE and updates the priority.
REQ-012 SHALL use round-robin arbitration in IDLE when both requesters are valid: the winner is the requester not granted last; after reset, requester 0 has priority.
REQ-013 SHALL, when only one requester is valid, grant that requester regardless of priority.
REQ-014 SHALL assert at most one of req0_ready and req1_ready per cycle, and only in IDLE.
REQ-015 SHALL assert at most one of rsp0_valid and rsp1_valid per cycle, and only in RESP.
REQ-016 SHALL have latency: request handshake in cycle N gives rspG_valid high from cycle N+2.
REQ-017 SHALL, with rspG_ready held high, return to IDLE in cycle N+3, giving throughput of one operation per 3 cycles.
REQ-018 SHALL hold alu_a, alu_b and alu_ctrl stable from the cycle after the handshake until the next handshake.
REQ-019 SHALL hold rsp_out and rsp_is_zero stable throughout RESP under backpressure (rspG_ready low for any number of cycles).
REQ-020 SHALL keep every other requester waiting during RESP; a requester's valid held high is not lost.
REQ-021 SHALL pass the ALU result through unmodified: no width change and no flag recomputation (rsp_is_zero = captured alu_is_zero).

Reset
REQ-022 SHALL, when rst is high at a clock edge, force state to IDLE, priority to requester 0, and all internal registers to 0.
REQ-023 SHALL have reset values of 0 for: reqN_ready, rspN_valid, rsp_out, rsp_is_zero, alu_a, alu_b, alu_ctrl, busy.
REQ-024 SHALL, on reset in EXEC or RESP, abort the in-flight operation and issue no response for it.
REQ-025 SHALL keep reqN_ready low while rst is high.

Configuration
REQ-026 SHALL, when macro ALU_ARBITER_RR_EN is defined, use round-robin arbitration as in REQ-012.
REQ-027 SHALL, when ALU_ARBITER_RR_EN is not defined, use fixed priority (requester 0 always wins a tie) and contain no priority register; all other behaviour is unchanged.

Verification
REQ-028 SHALL cover: req0 a=0x00000004, b=0x00000008, ctrl=0000 -> rsp0_valid at N+2 with rsp_out=0x0000000C and rsp_is_zero=0.
REQ-029 SHALL cover: req1 a=0xFFFFFFFF, b=0x00000001, ctrl=0000 -> rsp1_valid with rsp_out=0x00000000 and rsp_is_zero=1.
REQ-030 SHALL cover: both valid continuously with 4 ops each and RR enabled -> grants 0,1,0,1,... and each response matches its own operands.
REQ-031 SHALL cover: rsp0_ready low for 5 cycles -> rsp0_valid and rsp_out stable, req1_ready stays 0, and req1 is granted 1 cycle after rsp0_ready rises.
REQ-032 SHALL cover: rst pulsed during RESP -> the next cycle has all outputs 0 and state IDLE, and no stale rsp_valid appears afterwards.
REQ-033 SHALL cover: ALU_ARBITER_RR_EN undefined with both valid -> req0 granted every time and req1 starved until req0_valid drops.
